// File: rtl/gray_scale_pipe.sv
// Two-stage RGB-to-gray converter with valid/ready handshaking.
// S1 expands the channels and applies the mode weights; S2 sums, rounds and saturates.
module gray_scale_pipe #(
    parameter int unsigned CH_BITS   = 5,
    parameter int unsigned OUT_BITS  = 8,
    parameter bit          REPLICATE = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic [1:0]             mode_i,
    input  logic [3*CH_BITS-1:0]   in_px_rgb_i,
    input  logic                   in_valid_i,
    input  logic                   in_last_i,
    output logic                   in_ready_o,
    output logic [OUT_BITS-1:0]    out_px_gray_o,
    output logic                   out_valid_o,
    output logic                   out_last_o,
    input  logic                   out_ready_i,
    output logic [15:0]            px_count_o
);

    localparam int unsigned PROD_BITS = OUT_BITS + 9;
    localparam int unsigned SUM_BITS  = PROD_BITS + 2;

    // Vacated LSBs take the channel bits again from the MSB down, or zeros.
    function automatic logic [OUT_BITS-1:0] expand(input logic [CH_BITS-1:0] ch);
        logic [OUT_BITS-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < OUT_BITS; i++) begin
            if (REPLICATE || (i < CH_BITS)) begin
                res[OUT_BITS-1-i] = ch[CH_BITS-1-(i % CH_BITS)];
            end
        end
        return res;
    endfunction

    logic                 s1_valid_q;
    logic                 s1_last_q;
    logic [PROD_BITS-1:0] s1_pr_q;
    logic [PROD_BITS-1:0] s1_pg_q;
    logic [PROD_BITS-1:0] s1_pb_q;

    logic                 s2_valid_q;
    logic                 s2_last_q;
    logic [OUT_BITS-1:0]  s2_gray_q;

    logic [15:0]          count_q;

    logic                 s1_load;
    logic                 s2_load;
    logic                 in_fire;
    logic                 out_fire;

    logic [8:0]           w_r;
    logic [8:0]           w_g;
    logic [8:0]           w_b;
    logic [OUT_BITS-1:0]  exp_r;
    logic [OUT_BITS-1:0]  exp_g;
    logic [OUT_BITS-1:0]  exp_b;
    logic [PROD_BITS-1:0] prod_r;
    logic [PROD_BITS-1:0] prod_g;
    logic [PROD_BITS-1:0] prod_b;

    logic [SUM_BITS-1:0]  sum;
    logic [OUT_BITS+2:0]  rounded;
    logic [OUT_BITS-1:0]  gray_d;

    // A stage loads when empty or when its content advances this cycle.
    assign s2_load    = !s2_valid_q || out_ready_i;
    assign s1_load    = !s1_valid_q || s2_load;
    assign in_ready_o = enable_i && !reset_i && s1_load;
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = s2_valid_q && out_ready_i;

    always_comb begin
        w_r = 9'd0;
        w_g = 9'd0;
        w_b = 9'd0;
        unique case (mode_i)
            2'd0: begin w_r = 9'd77; w_g = 9'd150; w_b = 9'd29; end
            2'd1: begin w_r = 9'd54; w_g = 9'd183; w_b = 9'd19; end
            2'd2: begin w_r = 9'd85; w_g = 9'd86;  w_b = 9'd85; end
            2'd3: begin w_r = 9'd0;  w_g = 9'd256; w_b = 9'd0;  end
        endcase
    end

    always_comb begin
        exp_r  = expand(in_px_rgb_i[3*CH_BITS-1:2*CH_BITS]);
        exp_g  = expand(in_px_rgb_i[2*CH_BITS-1:CH_BITS]);
        exp_b  = expand(in_px_rgb_i[CH_BITS-1:0]);
        prod_r = PROD_BITS'(w_r) * PROD_BITS'(exp_r);
        prod_g = PROD_BITS'(w_g) * PROD_BITS'(exp_g);
        prod_b = PROD_BITS'(w_b) * PROD_BITS'(exp_b);
    end

    always_comb begin
        sum = SUM_BITS'(s1_pr_q) + SUM_BITS'(s1_pg_q) + SUM_BITS'(s1_pb_q) + SUM_BITS'(128);
        rounded = sum[SUM_BITS-1:8];
        gray_d  = rounded[OUT_BITS-1:0];
        if (|rounded[OUT_BITS+2:OUT_BITS]) begin
            gray_d = '1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_pr_q    <= '0;
            s1_pg_q    <= '0;
            s1_pb_q    <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_fire;
            if (in_fire) begin
                s1_last_q <= in_last_i;
                s1_pr_q   <= prod_r;
                s1_pg_q   <= prod_g;
                s1_pb_q   <= prod_b;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_gray_q  <= '0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_last_q <= s1_last_q;
                s2_gray_q <= gray_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (out_fire) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign out_valid_o   = s2_valid_q;
    assign out_last_o    = s2_last_q;
    assign out_px_gray_o = s2_gray_q;
    assign px_count_o    = count_q;

endmodule

// File: tb/tb_gray_scale_pipe.sv
// Self-checking bench for gray_scale_pipe: vector table, scoreboard, and
// hand-written sequences for backpressure, sideband, reset and enable corners.
module tb_gray_scale_pipe;

    logic        clk = 1'b0;
    logic        reset, enable, in_valid, in_last, out_ready;
    logic [1:0]  mode;
    logic [14:0] rgb;

    logic        in_ready, out_valid, out_last;
    logic [7:0]  gray;
    logic [15:0] px_count;

    logic        z_in_ready, z_out_valid, z_out_last;
    logic [7:0]  z_gray;
    logic [15:0] z_px_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_scale_pipe dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .mode_i(mode),
        .in_px_rgb_i(rgb), .in_valid_i(in_valid), .in_last_i(in_last),
        .in_ready_o(in_ready), .out_px_gray_o(gray), .out_valid_o(out_valid),
        .out_last_o(out_last), .out_ready_i(out_ready), .px_count_o(px_count)
    );

    gray_scale_pipe #(.CH_BITS(5), .OUT_BITS(8), .REPLICATE(1'b0)) dut_zero (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .mode_i(mode),
        .in_px_rgb_i(rgb), .in_valid_i(in_valid), .in_last_i(in_last),
        .in_ready_o(z_in_ready), .out_px_gray_o(z_gray), .out_valid_o(z_out_valid),
        .out_last_o(z_out_last), .out_ready_i(out_ready), .px_count_o(z_px_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Independent reference: 5-bit channels widened to 8 bits by MSB replication.
    function automatic int model(input logic [14:0] px, input logic [1:0] m);
        int r, g, b, wr, wg, wb, s;
        r = int'(px[14:10]); r = (r << 3) | (r >> 2);
        g = int'(px[9:5]);   g = (g << 3) | (g >> 2);
        b = int'(px[4:0]);   b = (b << 3) | (b >> 2);
        case (m)
            2'd0:    begin wr = 77; wg = 150; wb = 29; end
            2'd1:    begin wr = 54; wg = 183; wb = 19; end
            2'd2:    begin wr = 85; wg = 86;  wb = 85; end
            default: begin wr = 0;  wg = 256; wb = 0;  end
        endcase
        s = (wr * r + wg * g + wb * b + 128) >> 8;
        if (s > 255) s = 255;
        return s;
    endfunction

    typedef struct {
        int gray;
        bit last;
    } exp_t;

    exp_t       q[$];
    int         cnt_model  = 0;
    int         last_count = 0;
    int         last_pos   = 0;
    bit         hold_pend  = 1'b0;
    logic [7:0] hold_gray;
    logic       hold_last;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            q.delete();
            cnt_model  = 0;
            last_count = 0;
            last_pos   = 0;
            hold_pend  = 1'b0;
        end else begin
            check("px_count", px_count, cnt_model);
            if (hold_pend) begin
                check("hold_valid", out_valid, 1);
                check("hold_gray", gray, hold_gray);
                check("hold_last", out_last, hold_last);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got output %0d expected none", gray);
                end else begin
                    e = q.pop_front();
                    check("sb_gray", gray, e.gray);
                    check("sb_last", out_last, e.last);
                end
                if (out_last) begin
                    last_count++;
                    last_pos = cnt_model + 1;
                end
                cnt_model = (cnt_model + 1) & 16'hFFFF;
            end
            if (in_valid && in_ready) begin
                e.gray = model(rgb, mode);
                e.last = in_last;
                q.push_back(e);
            end
            hold_pend = out_valid && !out_ready;
            hold_gray = gray;
            hold_last = out_last;
        end
    end

    // Returns at posedge+1 after the transfer edge.
    task automatic offer(input logic [14:0] p, input logic [1:0] m, input logic l);
        rgb      = p;
        mode     = m;
        in_last  = l;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL offer_timeout: got no in_ready expected accept within 50 cycles");
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [14:0] px;
        logic [1:0]  m;
        int          gray;
    } vec_t;

    vec_t        tbl[10];
    logic [14:0] bp_px[3];
    logic [14:0] sb_px[6];
    int          acc;
    bit          fire;

    initial begin
        tbl[0] = '{15'h7FFF, 2'd0, 255};
        tbl[1] = '{15'h7C00, 2'd0, 77};
        tbl[2] = '{15'h7C00, 2'd1, 54};
        tbl[3] = '{15'h001F, 2'd2, 85};
        tbl[4] = '{15'h03E0, 2'd3, 255};
        tbl[5] = '{15'h4210, 2'd0, 132};
        tbl[6] = '{15'h4210, 2'd2, 132};
        tbl[7] = '{15'h0000, 2'd1, 0};
        tbl[8] = '{15'h001F, 2'd0, 29};
        tbl[9] = '{15'h03E0, 2'd0, 149};
        bp_px  = '{15'h7C00, 15'h03E0, 15'h001F};
        sb_px  = '{15'h7C00, 15'h03E0, 15'h001F, 15'h4210, 15'h5294, 15'h7FFF};

        reset     = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        mode      = 2'd0;
        rgb       = '0;

        // Reset state while reset is still held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_gray", gray, 0);
        check("rst_count", px_count, 0);
        check("rst_ready", in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // One pixel at a time: latency and value from the table.
        for (int i = 0; i < 10; i++) begin
            offer(tbl[i].px, tbl[i].m, 1'b0);
            @(negedge clk);
            check("lat_s1_valid", out_valid, 0);
            @(negedge clk);
            check("lat_valid", out_valid, 1);
            check("tbl_gray", gray, tbl[i].gray);
            if (i == 0) check("zero_fill_gray", z_gray, 248);
            @(posedge clk);
            #1;
        end

        // Backpressure: two stages fill, third pixel waits.
        do_reset();
        out_ready = 1'b0;
        acc       = 0;
        rgb       = bp_px[0];
        mode      = 2'd0;
        in_last   = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 24 && acc < 3; c++) begin
            if (c == 4) begin
                @(negedge clk);
                check("bp_accepted", acc, 2);
                check("bp_ready", in_ready, 0);
                check("bp_valid", out_valid, 1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            @(negedge clk);
            fire = in_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                acc++;
                if (acc < 3) rgb = bp_px[acc];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("bp_all_accepted", acc, 3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_count", px_count, 3);
        check("bp_drained", q.size(), 0);
        @(posedge clk);
        #1;

        // Sideband flag on pixel 4 with mode toggling every beat.
        do_reset();
        for (int k = 0; k < 6; k++) offer(sb_px[k], 2'(k % 2), k == 3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("last_count", last_count, 1);
        check("last_pos", last_pos, 4);
        check("sb_count", px_count, 6);
        @(posedge clk);
        #1;

        // Reset with two pixels in flight.
        offer(15'h7FFF, 2'd0, 1'b0);
        offer(15'h7C00, 2'd0, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", px_count, 0);
        @(negedge clk);
        check("mid_rst_stale", out_valid, 0);
        @(posedge clk);
        #1;
        offer(15'h03E0, 2'd1, 1'b0);
        @(negedge clk);
        check("post_rst_s1", out_valid, 0);
        @(negedge clk);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_gray", gray, model(15'h03E0, 2'd1));
        @(posedge clk);
        #1;

        // Enable drops mid-stream; accepted pixels still drain.
        offer(15'h5294, 2'd2, 1'b0);
        offer(15'h7C00, 2'd3, 1'b0);
        enable = 1'b0;
        @(negedge clk);
        check("en_low_ready", in_ready, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("en_drained", q.size(), 0);
        check("en_count", px_count, 3);
        @(posedge clk);
        #1;
        enable = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_scale_pipe.md
GRAY_SCALE_PIPE -- requirements
Module: gray_scale_pipe

Interface
REQ-001 Parameter CH_BITS, default 5, SHALL set the width of each input colour channel (1..OUT_BITS).
REQ-002 Parameter OUT_BITS, default 8, SHALL set the width of each expanded channel and of the gray output (2..12).
REQ-003 Parameter REPLICATE, default 1, SHALL select channel expansion: 1 = MSB replication, 0 = zero-fill.
REQ-004 Port clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port reset_i  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 Port enable_i  input  1  SHALL gate new pixel acceptance; when low, in_ready_o is low and the pipeline drains.
REQ-007 Port mode_i  input  2  SHALL select the weighting mode, sampled with each accepted pixel.
REQ-008 Port in_px_rgb_i  input  3*CH_BITS  SHALL carry R in [3C-1:2C], G in [2C-1:C] and B in [C-1:0].
REQ-009 Port in_valid_i  input  1  SHALL qualify in_px_rgb_i, mode_i and in_last_i.
REQ-010 Port in_last_i  input  1  SHALL be a sideband end-of-line flag carried alongside the pixel.
REQ-011 Port in_ready_o  output  1  SHALL indicate the block accepts a pixel this cycle.
REQ-012 Port out_px_gray_o  output  OUT_BITS  SHALL carry the gray result.
REQ-013 Port out_valid_o / out_last_o  output  1 each  SHALL qualify the result and carry the flag accepted with that pixel.
REQ-014 Port out_ready_i  input  1  SHALL be the downstream ready.
REQ-015 Port px_count_o  output  16  SHALL count completed output transfers.

Function
REQ-016 An input transfer SHALL occur when in_valid_i && in_ready_o, and an output transfer when out_valid_o && out_ready_i.
REQ-017 The pipeline SHALL have two register stages, S1 (expand and multiply) and S2 (sum, round, saturate), each with its own valid bit.
REQ-018 A stage SHALL load when it is empty or its content moves on in the same cycle.
REQ-019 in_ready_o SHALL equal enable_i && (!S1.valid || !S2.valid || out_ready_i).
REQ-020 Latency SHALL be 2 cycles from input transfer to out_valid_o with out_ready_i high, at a throughput of 1 pixel/cycle.
REQ-021 While out_valid_o is high and out_ready_i is low, out_px_gray_o and out_last_o SHALL hold stable; no pixel is dropped, duplicated or reordered.
REQ-022 Expansion SHALL be ch << (OUT_BITS-CH_BITS); when REPLICATE=1, the vacated LSBs SHALL be filled with the channel MSBs repeated (5-bit 31 -> 255, 16 -> 132).
REQ-023 The 9-bit weights (wR, wG, wB) SHALL be: mode 0 = (77,150,29) BT.601; mode 1 = (54,183,19) BT.709; mode 2 = (85,86,85) average; mode 3 = (0,256,0) green pass.
REQ-024 The result SHALL be (wR*R + wG*G + wB*B + 128) >> 8, saturated to 2^OUT_BITS-1; intermediate sums are full width with no overflow.
REQ-025 The mode SHALL travel with its pixel, so a mode_i change affects only pixels accepted afterwards.
REQ-026 px_count_o SHALL increment by 1 per output transfer and wrap from 0xFFFF to 0.
REQ-027 enable_i falling mid-stream SHALL still deliver every accepted pixel.

Reset
REQ-028 While reset_i is high at a clock edge, the block SHALL clear S1/S2 valid bits and data, out_valid_o, out_last_o, out_px_gray_o and px_count_o to 0, and drive in_ready_o to 0.
REQ-029 Reset asserted mid-stream SHALL discard in-flight pixels; the first output after release comes from a pixel accepted after release.

Verification
REQ-030 Bench SHALL cover reset: hold reset_i 2 cycles -> out_valid_o=0, out_px_gray_o=0, px_count_o=0, in_ready_o=0.
REQ-031 Bench SHALL cover modes 0 and 1 (defaults): 0x7FFF mode 0 -> 255 two cycles later; 0x7C00 mode 0 -> 77; 0x7C00 mode 1 -> 54.
REQ-032 Bench SHALL cover modes 2 and 3: 0x001F mode 2 -> 85; 0x03E0 mode 3 -> 255; REPLICATE=0 with 0x7FFF mode 0 -> 248.
REQ-033 Bench SHALL cover backpressure: out_ready_i low, 3 valid pixels offered -> 2 accepted, in_ready_o low, output held; release -> 3 results in order, px_count_o=3.
REQ-034 Bench SHALL cover sideband/mode: in_last_i=1 on pixel 4 with mode toggling every beat -> out_last_o only on output 4, each result matching its own mode.
REQ-035 Bench SHALL cover reset mid-stream: reset_i pulse with 2 pixels in flight -> no stale output, px_count_o=0, next accepted pixel emerges after 2 cycles.
